cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
Multi-cycle control sequencer for the tiny RV32I-subset CPU.
- Owns PC and IR.
- Fetches each instruction from instruction ROM over a req/valid handshake and decodes it.
- Drives register-file read/write addresses, the ALU operation select and write enable, one instruction at a time.
- Adds run/step/halt control and illegal-instruction trapping, so the datapath no longer executes free-running on the divided clock.

Parameters:
PC_W, 4, PC width in bits; instruction address space is 2^PC_W words
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  synchronous reset, active low
run_en  in  1  level: continuous execution while high
step  in  1  single-cycle pulse: execute exactly one instruction when stopped
halt_req  in  1  level: stop after the current instruction retires
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_rdata  in  32  instruction word, valid when imem_valid=1
imem_valid  in  1  fetch data valid; sampled only while imem_req=1
rf_raddr1  out  5  IR[19:15] (rs1)
rf_raddr2  out  5  IR[24:20] (rs2)
rf_waddr  out  5  IR[11:7] (rd)
rf_we  out  1  register-file write strobe, one cycle
alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
alu_src_imm  out  1  1 = operand B is sign-extended IR[31:20]
pc  out  PC_W  current program counter
halted  out  1  high in IDLE or ERROR
illegal  out  1  sticky: illegal instruction trapped
retire_pulse  out  1  one cycle per retired instruction
retire_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
Reset (RST_N=0 at CLK edge, from any state, including mid-fetch):
- state=IDLE; pc=0; IR=0; retire_count=0; illegal=0.
- imem_req, rf_we, retire_pulse, alu_op, alu_src_imm all 0.
- halted=1 from the first cycle after reset.

States:
- IDLE:
  - run_en=1 and halt_req=0 -> FETCH.
  - Else step=1 and halt_req=0 -> FETCH with a one-shot flag set.
  - Otherwise stay.
  - run_en and step both high: treated as run.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stay until imem_valid=1; on that edge IR<=imem_rdata -> DECODE.
  - No timeout. Fetch may complete in the same cycle as the request.
- DECODE: classify IR, latch alu_op, alu_src_imm and a write-allowed flag.
  - opcode 0110011, funct7=0000000: funct3 000 ADD, 111 AND, 110 OR, 100 XOR.
  - opcode 0110011, funct7=0100000, funct3 000: SUB.
  - opcode 0010011: funct3 000 ADDI, 111 ANDI, 110 ORI (all with alu_src_imm=1).
  - IR=32'h0: NOP, no write.
  - Any other encoding -> ERROR.
- EXECUTE: one cycle for the ALU to settle; alu_op, alu_src_imm and address outputs held stable.
- WRITEBACK:
  - rf_we=1 for exactly this cycle if write allowed and rd!=0. Never written when rd=0, and never for NOP.
  - pc<=pc+1, wrapping 2^PC_W-1 -> 0.
  - retire_pulse=1; retire_count+1.
  - Next state: FETCH if run_en=1, halt_req=0 and not one-shot; else IDLE (one-shot cleared).
- ERROR: illegal=1 sticky.
  - pc stays at the faulting address; no write, no retire.
  - Left only by reset.

Timing and stability:
- Minimum latency: 4 cycles per instruction with zero-wait fetch.
- halt_req asserted mid-instruction: the instruction completes and retires, then IDLE.
- step while running or in ERROR: ignored.
- rf_raddr1/2 and rf_waddr are combinational from IR; alu_op is registered.
- All outputs stay stable from DECODE exit until WRITEBACK exit.

Test Plan:
- Reset, ROM={00500093,00300113,002081B3}, run_en=1, zero-wait fetch -> rf_we at cycles 4, 8, 12; rf_waddr=1, 2, 3; alu_op=ADD; alu_src_imm=1, 1, 0; retire_count=3 at cycle 12.
- run_en=0, three step pulses spaced 10 cycles apart -> exactly 3 retire_pulses; pc 0->1->2->3; halted=1 between steps.
- Word 40000033 (SUB x0) then 0071F213 (ANDI) -> no rf_we for rd=0 but retire_pulse fires; then alu_op=2, rf_we=1, rf_waddr=4.
- Word 0000007F (illegal) at pc=2 -> ERROR; illegal=1; pc stays 2; no rf_we; asserting step has no effect; RST_N=0 clears illegal and pc=0.
- PC_W=4, run through 16 NOPs -> pc wraps 15->0; retire_count=16; no rf_we.
- imem_valid delayed 3 cycles, halt_req raised in EXECUTE, RST_N pulsed during a later FETCH:
  - imem_req is held for the full 3-cycle wait.
  - The instruction retires, then IDLE.
  - The reset drops imem_req the next cycle, and pc=0.

Source files
------------

// File: rtl/cpu_seq_ctrl_if.sv
// Fetch and datapath-control bundle between the sequencer and the CPU core.
// Latency: none (wires only).
// Backpressure: the fetch side holds imem_req until the memory answers with imem_valid.
interface cpu_seq_ctrl_if #(
    parameter int PC_W = 4
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;
    logic [4:0]      rf_raddr1;
    logic [4:0]      rf_raddr2;
    logic [4:0]      rf_waddr;
    logic            rf_we;
    logic [2:0]      alu_op;
    logic            alu_src_imm;

    modport master (
        output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, alu_op, alu_src_imm,
        input  imem_rdata, imem_valid
    );

    modport slave (
        input  imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, alu_op, alu_src_imm,
        output imem_rdata, imem_valid
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer: fetch, decode, execute, writeback with run/step/halt and illegal trap.
// Latency: 4 cycles per instruction with a zero-wait fetch, plus one IDLE cycle to start.
// Backpressure: FETCH waits indefinitely for imem_valid; imem_req stays high meanwhile.
module cpu_seq_ctrl #(
    parameter int PC_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run_en,
    input  logic             step,
    input  logic             halt_req,
    cpu_seq_ctrl_if.master   bus,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             illegal,
    output logic             retire_pulse,
    output logic [CNT_W-1:0] retire_count
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ir;
    logic [2:0]  alu_op_q;
    logic        alu_src_imm_q;
    logic        wr_ok_q;
    logic        one_shot;

    logic        dec_legal;
    logic        dec_wr;
    logic        dec_imm;
    logic [2:0]  dec_op;

    logic        ld_ir;
    logic        ld_dec;
    logic        ld_once;
    logic        once_val;
    logic        trap;
    logic        retire;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Register addresses come straight from IR so the register file sees them during EXECUTE.
    assign bus.rf_raddr1   = ir[19:15];
    assign bus.rf_raddr2   = ir[24:20];
    assign bus.rf_waddr    = ir[11:7];
    assign bus.imem_addr   = pc;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_src_imm = alu_src_imm_q;

    assign retire_pulse = retire;
    assign halted       = (state == S_IDLE) || (state == S_ERROR);

    // Classify the held instruction word; an all-zero word is a NOP that never writes.
    always_comb begin
        dec_legal = 1'b0;
        dec_wr    = 1'b0;
        dec_imm   = 1'b0;
        dec_op    = ALU_ADD;
        if (ir == 32'h0) begin
            dec_legal = 1'b1;
        end else if (opcode == OPC_OP) begin
            if (funct7 == 7'b0000000) begin
                case (funct3)
                    3'b000:  begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    3'b111:  begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    3'b110:  begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    3'b100:  begin dec_legal = 1'b1; dec_op = ALU_XOR; end
                    default: dec_legal = 1'b0;
                endcase
            end else if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
                dec_legal = 1'b1;
                dec_op    = ALU_SUB;
            end
            dec_wr = dec_legal;
        end else if (opcode == OPC_OPIMM) begin
            dec_imm = 1'b1;
            case (funct3)
                3'b000:  begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                3'b111:  begin dec_legal = 1'b1; dec_op = ALU_AND; end
                3'b110:  begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                default: dec_legal = 1'b0;
            endcase
            dec_wr = dec_legal;
        end
    end

    // State register; reset lands in IDLE from anywhere, including mid-fetch.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic plus the per-state strobes that steer the datapath registers.
    always_comb begin
        state_nx      = state;
        ld_ir         = 1'b0;
        ld_dec        = 1'b0;
        ld_once       = 1'b0;
        once_val      = 1'b0;
        trap          = 1'b0;
        retire        = 1'b0;
        bus.imem_req  = 1'b0;
        bus.rf_we     = 1'b0;
        case (state)
            S_IDLE: begin
                // run_en wins over step, so a simultaneous step is a plain run.
                if (!halt_req && (run_en || step)) begin
                    state_nx = S_FETCH;
                    ld_once  = 1'b1;
                    once_val = !run_en;
                end
            end
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_valid) begin
                    ld_ir    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    ld_dec   = 1'b1;
                    state_nx = S_EXECUTE;
                end else begin
                    trap     = 1'b1;
                    state_nx = S_ERROR;
                end
            end
            S_EXECUTE: begin
                state_nx = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                retire    = 1'b1;
                bus.rf_we = wr_ok_q && (ir[11:7] != 5'd0);
                ld_once   = 1'b1;
                once_val  = 1'b0;
                if (run_en && !halt_req && !one_shot) begin
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ERROR: begin
                state_nx = S_ERROR;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Architectural and control registers: IR, latched decode, PC, counters, sticky trap.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc            <= '0;
            ir            <= '0;
            alu_op_q      <= ALU_ADD;
            alu_src_imm_q <= 1'b0;
            wr_ok_q       <= 1'b0;
            one_shot      <= 1'b0;
            illegal       <= 1'b0;
            retire_count  <= '0;
        end else begin
            if (ld_ir) begin
                ir <= bus.imem_rdata;
            end
            if (ld_dec) begin
                alu_op_q      <= dec_op;
                alu_src_imm_q <= dec_imm;
                wr_ok_q       <= dec_wr;
            end
            if (ld_once) begin
                one_shot <= once_val;
            end
            if (trap) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                pc           <= pc + PC_W'(1);
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed programs with an instruction-level reference model.
// Latency: model expects writeback three cycles after the fetch handshake.
// Backpressure: the ROM responder delays imem_valid by fetch_wait cycles.
module tb_cpu_seq_ctrl;
    localparam int PC_W  = 4;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             run_en;
    logic             step;
    logic             halt_req;
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic             illegal;
    logic             retire_pulse;
    logic [CNT_W-1:0] retire_count;

    cpu_seq_ctrl_if #(.PC_W(PC_W)) bus ();

    cpu_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .run_en       (run_en),
        .step         (step),
        .halt_req     (halt_req),
        .bus          (bus),
        .pc           (pc),
        .halted       (halted),
        .illegal      (illegal),
        .retire_pulse (retire_pulse),
        .retire_count (retire_count)
    );

    always #5 CLK = ~CLK;

    // Instruction ROM with a programmable fetch wait.
    logic [31:0] rom [16];
    int          fetch_wait = 0;
    int          wcnt = 0;
    assign bus.imem_rdata = rom[bus.imem_addr];
    assign bus.imem_valid = bus.imem_req && (wcnt >= fetch_wait);
    always @(posedge CLK) wcnt <= (bus.imem_req && !bus.imem_valid) ? wcnt + 1 : 0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction semantics: legality, whether rd is written, ALU op, immediate operand.
    function automatic void dec(input logic [31:0] w, output logic ok, output logic wr,
                                output logic [2:0] op, output logic imm);
        ok = 1'b0; wr = 1'b0; op = 3'd0; imm = 1'b0;
        if (w == 32'h0) begin
            ok = 1'b1;
        end else if (w[6:0] == 7'h33) begin
            case ({w[31:25], w[14:12]})
                10'b0000000_000: begin ok = 1'b1; op = 3'd0; end
                10'b0100000_000: begin ok = 1'b1; op = 3'd1; end
                10'b0000000_111: begin ok = 1'b1; op = 3'd2; end
                10'b0000000_110: begin ok = 1'b1; op = 3'd3; end
                10'b0000000_100: begin ok = 1'b1; op = 3'd4; end
                default: ok = 1'b0;
            endcase
            wr = ok;
        end else if (w[6:0] == 7'h13) begin
            imm = 1'b1;
            case (w[14:12])
                3'b000: begin ok = 1'b1; op = 3'd0; end
                3'b111: begin ok = 1'b1; op = 3'd2; end
                3'b110: begin ok = 1'b1; op = 3'd3; end
                default: ok = 1'b0;
            endcase
            wr = ok;
        end
    endfunction

    // Model state: mode 0 stopped, 1 executing, 2 trapped; k = cycles since fetch accepted.
    int              m_mode = 0;
    int              m_k    = 0;
    logic [PC_W-1:0] m_pc   = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic            m_ill  = 1'b0;
    logic            m_once = 1'b0;
    logic [31:0]     m_word = '0;
    logic            s_rst = 1'b0, s_run = 1'b0, s_step = 1'b0, s_halt = 1'b0, s_valid = 1'b0;
    logic [31:0]     s_rdata = '0;

    int          we_cyc [$];
    logic [4:0]  we_rd [$];
    logic [2:0]  we_op [$];
    logic        we_imm [$];
    int          rp_seen = 0;

    // Advance the model over the edge just passed, then compare every output.
    always @(negedge CLK) begin
        logic ok, wr, imm, act, rst_now;
        logic [2:0] op;
        rst_now = !s_rst;
        if (!s_rst) begin
            m_mode = 0; m_k = 0; m_pc = '0; m_cnt = '0; m_ill = 1'b0; m_once = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (s_run && !s_halt) begin m_mode = 1; m_k = 0; m_once = 1'b0; end
                    else if (s_step && !s_halt) begin m_mode = 1; m_k = 0; m_once = 1'b1; end
                end
                1: begin
                    case (m_k)
                        0: if (s_valid) begin m_word = s_rdata; m_k = 1; end
                        1: begin
                            dec(m_word, ok, wr, op, imm);
                            if (!ok) begin m_mode = 2; m_ill = 1'b1; end
                            else m_k = 2;
                        end
                        2: m_k = 3;
                        default: begin
                            m_pc  = m_pc + 1'b1;
                            m_cnt = m_cnt + 1'b1;
                            if (s_run && !s_halt && !m_once) m_k = 0;
                            else m_mode = 0;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        dec(m_word, ok, wr, op, imm);
        act = (m_mode == 1);
        chk("imem_req", bus.imem_req, act && (m_k == 0));
        if (act && m_k == 0) chk("imem_addr", bus.imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("retire_count", retire_count, m_cnt);
        chk("illegal", illegal, m_ill);
        chk("halted", halted, !act);
        chk("retire_pulse", retire_pulse, act && (m_k == 3));
        chk("rf_we", bus.rf_we, act && (m_k == 3) && wr && (m_word[11:7] != 5'd0));
        if (act && m_k >= 1) begin
            chk("rf_raddr1", bus.rf_raddr1, m_word[19:15]);
            chk("rf_raddr2", bus.rf_raddr2, m_word[24:20]);
            chk("rf_waddr", bus.rf_waddr, m_word[11:7]);
        end
        if (act && m_k >= 2 && wr) begin
            chk("alu_op", bus.alu_op, op);
            chk("alu_src_imm", bus.alu_src_imm, imm);
        end
        if (rst_now) begin
            chk("alu_op_rst", bus.alu_op, 3'd0);
            chk("alu_src_imm_rst", bus.alu_src_imm, 1'b0);
        end

        if (bus.rf_we === 1'b1) begin
            we_cyc.push_back(cyc);
            we_rd.push_back(bus.rf_waddr);
            we_op.push_back(bus.alu_op);
            we_imm.push_back(bus.alu_src_imm);
        end
        if (retire_pulse === 1'b1) rp_seen++;

        s_rst = RST_N; s_run = run_en; s_step = step; s_halt = halt_req;
        s_valid = bus.imem_valid; s_rdata = bus.imem_rdata;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick(2);
        RST_N = 1'b1;
        we_cyc.delete(); we_rd.delete(); we_op.delete(); we_imm.delete();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    endtask

    initial begin
        int          c0;
        int          r0;
        logic [31:0] t1_imm [3];
        RST_N = 1'b0; run_en = 1'b0; step = 1'b0; halt_req = 1'b0;
        clear_rom();

        // Reset state.
        tick(2);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 1);
        chk("rst_illegal", illegal, 0);
        chk("rst_count", retire_count, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_we", bus.rf_we, 0);

        // Free run: ADDI x1, ADDI x2, ADD x3.
        rom[0] = 32'h00500093; rom[1] = 32'h00300113; rom[2] = 32'h002081B3;
        t1_imm[0] = 1; t1_imm[1] = 1; t1_imm[2] = 0;
        do_reset();
        run_en = 1'b1; c0 = cyc;
        tick(12);
        run_en = 1'b0;
        tick(3);
        chk("t1_we_count", we_cyc.size(), 3);
        for (int j = 0; j < 3 && j < we_cyc.size(); j++) begin
            chk("t1_we_cycle", we_cyc[j] - c0, 4 * (j + 1));
            chk("t1_waddr", we_rd[j], j + 1);
            chk("t1_alu_op", we_op[j], 0);
            chk("t1_src_imm", we_imm[j], t1_imm[j]);
        end
        chk("t1_count", retire_count, 3);
        chk("t1_pc", pc, 3);

        // Single step three times.
        clear_rom();
        do_reset();
        r0 = rp_seen;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(1); step = 1'b0; tick(9);
            chk("t2_pc", pc, i + 1);
            chk("t2_halted", halted, 1);
        end
        chk("t2_retires", rp_seen - r0, 3);
        chk("t2_no_we", we_cyc.size(), 0);

        // SUB x0 retires without a write, then ANDI x4.
        rom[0] = 32'h40000033; rom[1] = 32'h0071F213;
        do_reset();
        r0 = rp_seen;
        run_en = 1'b1; c0 = cyc;
        tick(8);
        run_en = 1'b0;
        tick(3);
        chk("t3_retires", rp_seen - r0, 2);
        chk("t3_we_count", we_cyc.size(), 1);
        if (we_cyc.size() > 0) begin
            chk("t3_we_cycle", we_cyc[0] - c0, 8);
            chk("t3_waddr", we_rd[0], 4);
            chk("t3_alu_op", we_op[0], 2);
            chk("t3_src_imm", we_imm[0], 1);
        end

        // Illegal word at pc=2.
        clear_rom();
        rom[2] = 32'h0000007F;
        do_reset();
        run_en = 1'b1;
        tick(20);
        chk("t4_illegal", illegal, 1);
        chk("t4_pc", pc, 2);
        chk("t4_halted", halted, 1);
        chk("t4_count", retire_count, 2);
        chk("t4_no_we", we_cyc.size(), 0);
        run_en = 1'b0; step = 1'b1; tick(1); step = 1'b0; tick(5);
        chk("t4_step_req", bus.imem_req, 0);
        chk("t4_step_pc", pc, 2);
        chk("t4_step_ill", illegal, 1);
        RST_N = 1'b0; tick(1); RST_N = 1'b1;
        chk("t4_rst_ill", illegal, 0);
        chk("t4_rst_pc", pc, 0);

        // Sixteen NOPs wrap the PC.
        clear_rom();
        do_reset();
        run_en = 1'b1;
        tick(64);
        run_en = 1'b0;
        tick(3);
        chk("t5_pc", pc, 0);
        chk("t5_count", retire_count, 16);
        chk("t5_no_we", we_cyc.size(), 0);

        // Slow fetch, halt in EXECUTE, reset during a later fetch.
        rom[0] = 32'h00500093;
        fetch_wait = 3;
        do_reset();
        run_en = 1'b1;
        tick(1);
        for (int j = 0; j < 4; j++) begin
            chk("t6_req_held", bus.imem_req, 1);
            tick(1);
        end
        chk("t6_req_done", bus.imem_req, 0);
        tick(1);
        halt_req = 1'b1;
        tick(3);
        chk("t6_halted", halted, 1);
        chk("t6_count", retire_count, 1);
        chk("t6_pc", pc, 1);
        chk("t6_we_count", we_cyc.size(), 1);
        halt_req = 1'b0;
        tick(2);
        chk("t6_refetch", bus.imem_req, 1);
        RST_N = 1'b0;
        tick(1);
        chk("t6_rst_req", bus.imem_req, 0);
        chk("t6_rst_pc", pc, 0);
        RST_N = 1'b1; run_en = 1'b0; fetch_wait = 0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
